// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MD_IDLE / MD_START / MD_ABORT : 2-bit MulCtrl/DivCtrl command codes,
//                                   also decoded by the control FSM
//   md_state_t                    : state encoding of the unit's FSM
package md_pkg;

   localparam logic [1:0] MD_IDLE  = 2'b00;
   localparam logic [1:0] MD_START = 2'b01;
   localparam logic [1:0] MD_ABORT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_FIX,
      S_DONE
   } md_state_t;

endpackage

// File: rtl/md_addsub.sv
// Combinational W-bit adder/subtractor with carry out.
// It is shared by the multiply accumulate step and the divide trial subtract.
//   i_a, i_b : operands
//   i_sub    : 1 = i_a - i_b, 0 = i_a + i_b
//   o_sum    : W-bit result
//   o_cout   : carry out; when subtracting, 1 means no borrow (i_a >= i_b)
module md_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   logic [W-1:0] w_b;
   logic [W:0]   w_res;

   assign w_b    = i_sub ? ~i_b : i_b;
   assign w_res  = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_sub};
   assign o_sum  = w_res[W-1:0];
   assign o_cout = w_res[W];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide unit.
// It works on operand magnitudes and applies the result signs in a final fix-up cycle.
//   clck, reset      : clock, synchronous active-high reset
//   MulCtrl, DivCtrl : 00 idle, 01 start, 11 abort, 10 treated as idle
//   A, B             : operands (dividend / divisor), sampled on the start edge only
//   HI, LO           : product high/low word, or remainder/quotient
//   Done             : one-cycle pulse when HI/LO were just written
//   DivZero          : one-cycle pulse after a divide was started with B == 0
//   Busy             : high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | waiting for a start command
// MULT   | one shift-add step per cycle, WIDTH steps
// DIV    | one restoring-division step per cycle, WIDTH steps
// FIX    | apply signs and write HI/LO (skipped on abort)
// DONE   | Done pulse, back to IDLE
module mult_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clck,
   input  logic             reset,
   input  logic [1:0]       MulCtrl,
   input  logic [1:0]       DivCtrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Done,
   output logic             DivZero,
   output logic             Busy
);

   md_state_t          r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opnd, r_hi, r_lo;
   logic               r_is_div, r_neg_lo, r_neg_hi, r_divzero;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_mul_start, w_div_start, w_abort, w_b_zero, w_last;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;
   logic [WIDTH:0]     w_as_a, w_as_b, w_sum;
   logic               w_as_sub, w_cout;

   assign w_mul_start = (MulCtrl == MD_START);
   assign w_div_start = (DivCtrl == MD_START);
   assign w_abort     = (MulCtrl == MD_ABORT) || (DivCtrl == MD_ABORT);
   assign w_b_zero    = (B == '0);
   assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

   // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
   assign w_abs_a = A[WIDTH-1] ? -A : A;
   assign w_abs_b = B[WIDTH-1] ? -B : B;

   // MULT: {r_acc_hi, r_acc_lo} is the accumulator, with the multiplier in the low half.
   // DIV: r_acc_hi is the partial remainder, and the dividend shifts out of r_acc_lo
   // while the quotient bits shift in.
   assign w_as_sub = (r_state == S_DIV);
   assign w_as_a   = (r_state == S_DIV) ? {r_acc_hi, r_acc_lo[WIDTH-1]} : {1'b0, r_acc_hi};
   assign w_as_b   = ((r_state == S_DIV) || r_acc_lo[0]) ? {1'b0, r_opnd} : '0;

   md_addsub #(.W(WIDTH + 1)) u_addsub (
      .i_a    (w_as_a),
      .i_b    (w_as_b),
      .i_sub  (w_as_sub),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   assign w_prod     = {r_acc_hi, r_acc_lo};
   assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
   assign w_quo_fix  = r_neg_lo ? -r_acc_lo : r_acc_lo;
   assign w_rem_fix  = r_neg_hi ? -r_acc_hi : r_acc_hi;

   always_ff @(posedge clck) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      Done        = 1'b0;
      Busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_mul_start)                  w_state_nxt = S_MULT;
            else if (w_div_start && !w_b_zero) w_state_nxt = S_DIV;
         end
         S_MULT: begin
            if (w_abort)     w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_FIX;
         end
         S_DIV: begin
            if (w_abort)     w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_FIX;
         end
         S_FIX:   w_state_nxt = w_abort ? S_IDLE : S_DONE;
         S_DONE: begin
            Done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clck) begin
      if (reset) begin
         r_acc_hi  <= '0;
         r_acc_lo  <= '0;
         r_opnd    <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_is_div  <= 1'b0;
         r_neg_lo  <= 1'b0;
         r_neg_hi  <= 1'b0;
         r_divzero <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_divzero <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_mul_start) begin
                  r_acc_hi <= '0;
                  r_acc_lo <= w_abs_b;
                  r_opnd   <= w_abs_a;
                  r_neg_lo <= A[WIDTH-1] ^ B[WIDTH-1];
                  r_neg_hi <= A[WIDTH-1] ^ B[WIDTH-1];
                  r_is_div <= 1'b0;
                  r_cnt    <= '0;
               end else if (w_div_start) begin
                  if (w_b_zero) begin
                     r_divzero <= 1'b1;
                  end else begin
                     r_acc_hi <= '0;
                     r_acc_lo <= w_abs_a;
                     r_opnd   <= w_abs_b;
                     r_neg_lo <= A[WIDTH-1] ^ B[WIDTH-1];
                     r_neg_hi <= A[WIDTH-1];
                     r_is_div <= 1'b1;
                     r_cnt    <= '0;
                  end
               end
            end
            S_MULT: begin
               r_acc_hi <= w_sum[WIDTH:1];
               r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
               r_cnt    <= r_cnt + CNT_W'(1);
            end
            S_DIV: begin
               // The carry out of the trial subtract means no borrow: keep the difference.
               r_acc_hi <= w_cout ? w_sum[WIDTH-1:0] : w_as_a[WIDTH-1:0];
               r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_cout};
               r_cnt    <= r_cnt + CNT_W'(1);
            end
            S_FIX: begin
               if (!w_abort) begin
                  if (r_is_div) begin
                     r_lo <= w_quo_fix;
                     r_hi <= w_rem_fix;
                  end else begin
                     {r_hi, r_lo} <= w_prod_fix;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign HI      = r_hi;
   assign LO      = r_lo;
   assign DivZero = r_divzero;

endmodule
